w21_rom_seq_ctrl: RTL and testbench
===================================

// Module: w21_rom_seq_ctrl
// PURPOSE
//  Sequencer for one 21-bit signed weight-ROM column (w21_rom_c* family, 300 entries).
//  On start, walks ROM addresses 0..DEPTH-1 and streams each weight, with its address,
//  to the downstream MAC over a valid/ready handshake with full backpressure.
//  Signals completion and supports abort. One instance per ROM column in the layer datapath.
// PARAMETERS
//  ADDR_W  9    ROM address width
//  DATA_W  21   weight width (two's complement, passed through unmodified)
//  DEPTH   300  entries walked per run; legal range 1..2**ADDR_W
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       synchronous, active-high reset
//  start      in   1       one-cycle run request; honoured only in IDLE
//  abort      in   1       terminate current run, no done pulse
//  rom_adrs   out  ADDR_W  address to ROM adrs_clm (ROM is combinational)
//  rom_data   in   DATA_W  ROM out for rom_adrs, same cycle
//  w_data     out  DATA_W  registered weight
//  w_addr     out  ADDR_W  address that w_data was read from
//  w_valid    out  1       w_data/w_addr/w_last valid
//  w_last     out  1       beat carries address DEPTH-1
//  w_ready    in   1       downstream accepts beat when w_valid&&w_ready
//  busy       out  1       high in RUN and DRAIN
//  done       out  1       one-cycle pulse after last beat accepted
// BEHAVIOUR
//  - Reset: state IDLE, rom_adrs=0, w_data=0, w_addr=0, w_valid=0, w_last=0, busy=0, done=0.
//  - FSM IDLE->RUN on start; RUN->DRAIN when beat DEPTH-1 loaded; DRAIN->IDLE when that beat
//    accepted (done=1 on the next cycle); any state->IDLE on abort.
//  - Addr counter cnt drives rom_adrs. Entering RUN sets cnt=0.
//  - load = (state==RUN) && (!w_valid || w_ready). On load: w_data<=rom_data, w_addr<=cnt,
//    w_valid<=1, w_last<=(cnt==DEPTH-1), cnt<=cnt+1 unless cnt==DEPTH-1 (then hold, go DRAIN).
//  - Accept without load (DRAIN or RUN not loading): w_valid<=0, w_last<=0.
//  - Stalled (w_valid && !w_ready): w_data/w_addr/w_last/w_valid and cnt hold; beat never
//    dropped or duplicated.
//  - Latency: start at edge k -> first beat (addr 0) valid in cycle after edge k+1; with
//    w_ready tied high, one beat per cycle, DEPTH beats in DEPTH consecutive cycles,
//    done pulse one cycle after final accept.
//  - start while busy: ignored. start and abort same cycle in IDLE: abort wins, stay IDLE.
//  - abort: next edge w_valid=0, w_last=0, cnt=0, busy=0, done=0; in-flight beat discarded.
//  - rst overrides abort and start; rst mid-run equals reset values above.
//  - cnt never exceeds DEPTH-1; rom_adrs outside 0..DEPTH-1 never driven. DEPTH=1: single
//    beat with w_last=1.
//  - busy = (state!=IDLE) combinationally from state register; done is registered.
// STRUCTURE
//  - Package w21_rom_seq_pkg: state enum {IDLE, RUN, DRAIN}, W21_DEPTH=300, W21_ADDR_W=9,
//    W21_DATA_W=21; shared by all column sequencers and the layer top.
//  - One natural sub-module: w21_beat_reg (data/addr/last register + valid/ready hold),
//    reusable by other weight streamers. FSM and counter stay in this module.
// TESTING
//  - rst, start, w_ready=1 -> beat0 w_data=21'h000160 addr 0; beat1 21'h000271 addr 1;
//    beat299 21'h1FFFC1 w_last=1; exactly 300 beats, done 1 cycle after.
//  - w_ready low 5 cycles while beat 2 valid -> w_data/w_addr stable, rom_adrs held;
//    resume yields addr 3 next, no gaps/duplicates; random w_ready 30% -> 300 beats in order.
//  - abort while w_addr=150, w_ready=0 -> next cycle w_valid=0, busy=0, no done; new start
//    restarts at addr 0.
//  - start pulsed during RUN at addr 40 and in DRAIN -> ignored, count stays 300, one done.
//  - rst asserted at addr 77 -> all outputs reset values next cycle; start+abort together
//    in IDLE -> stays IDLE.
//  - DEPTH=1 build: single beat addr 0, w_last=1, done next cycle after accept.

Source files
------------

// File: rtl/w21_rom_seq_pkg.sv
// Shared types and sizing for the 21-bit weight-ROM column sequencers.
// Imported by every column sequencer and by the layer top.
package w21_rom_seq_pkg;

    localparam int W21_DEPTH  = 300;
    localparam int W21_ADDR_W = 9;
    localparam int W21_DATA_W = 21;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/w21_beat_reg.sv
// Single-entry output register for a weight stream: data/addr/last plus valid,
// held while the consumer stalls so a beat is never dropped or repeated.
module w21_beat_reg
    import w21_rom_seq_pkg::*;
#(
    parameter int ADDR_W = W21_ADDR_W,
    parameter int DATA_W = W21_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic              free_o,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              last_q;
    logic              valid_q;

    // Callers only load when free_o is high, so a stalled beat is never overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            addr_q  <= addr_i;
            last_q  <= last_i;
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end
    end

    assign free_o  = !valid_q || ready_i;
    assign data_o  = data_q;
    assign addr_o  = addr_q;
    assign last_o  = last_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/w21_rom_seq_ctrl.sv
// Walks one weight-ROM column from address 0 to DEPTH-1 and streams each weight,
// tagged with its address, to the MAC over valid/ready with full backpressure.
module w21_rom_seq_ctrl
    import w21_rom_seq_pkg::*;
#(
    parameter int ADDR_W = W21_ADDR_W,
    parameter int DATA_W = W21_DATA_W,
    parameter int DEPTH  = W21_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_adrs,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] w_data,
    output logic [ADDR_W-1:0] w_addr,
    output logic              w_valid,
    output logic              w_last,
    input  logic              w_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              done_q;
    logic              slot_free;
    logic              load;
    logic              at_last;

    assign at_last = (cnt_q == LAST_ADDR);
    assign load    = (state_q == RUN) && slot_free;

    // The counter parks at LAST_ADDR in DRAIN, so rom_adrs never leaves 0..DEPTH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q <= RUN;
                            cnt_q   <= '0;
                        end
                    end
                    RUN: begin
                        if (load) begin
                            if (at_last) begin
                                state_q <= DRAIN;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (w_valid && w_ready) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            done_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    w21_beat_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_beat (
        .clk     (clk),
        .rst     (rst),
        .flush_i (abort),
        .load_i  (load),
        .data_i  (rom_data),
        .addr_i  (cnt_q),
        .last_i  (at_last),
        .ready_i (w_ready),
        .free_o  (slot_free),
        .data_o  (w_data),
        .addr_o  (w_addr),
        .last_o  (w_last),
        .valid_o (w_valid)
    );

    assign rom_adrs = cnt_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_w21_rom_seq_ctrl.sv
// Directed + randomized bench for the weight-ROM column sequencer; a stream-level
// model (expected next index, run-active flag) checks every cycle.
module tb_w21_rom_seq_ctrl;
    import w21_rom_seq_pkg::*;

    localparam int AW = W21_ADDR_W;
    localparam int DW = W21_DATA_W;
    localparam int D  = W21_DEPTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, abort, w_ready;
    logic [AW-1:0] rom_adrs, w_addr;
    logic [DW-1:0] rom_data, w_data;
    logic          w_valid, w_last, busy, done;

    logic          start1, w_ready1;
    logic [AW-1:0] rom_adrs1, w_addr1;
    logic [DW-1:0] rom_data1, w_data1;
    logic          w_valid1, w_last1, busy1, done1;

    int n_checks  = 0;
    int n_errors  = 0;
    int exp_idx   = 0;
    int runs_done = 0;
    bit run_exp   = 1'b0;

    // Column contents: three known entries, the rest a fixed hash of the address.
    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        logic [31:0] h;
        case (a)
            9'd0:    return 21'h000160;
            9'd1:    return 21'h000271;
            9'd299:  return 21'h1FFFC1;
            default: begin
                h = 32'(a) * 32'h9E3779B1;
                return h[27:7];
            end
        endcase
    endfunction

    assign rom_data  = rom_fn(rom_adrs);
    assign rom_data1 = rom_fn(rom_adrs1);

    w21_rom_seq_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .rom_adrs (rom_adrs),
        .rom_data (rom_data),
        .w_data   (w_data),
        .w_addr   (w_addr),
        .w_valid  (w_valid),
        .w_last   (w_last),
        .w_ready  (w_ready),
        .busy     (busy),
        .done     (done)
    );

    w21_rom_seq_ctrl #(.DEPTH(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .start    (start1),
        .abort    (abort),
        .rom_adrs (rom_adrs1),
        .rom_data (rom_data1),
        .w_data   (w_data1),
        .w_addr   (w_addr1),
        .w_valid  (w_valid1),
        .w_last   (w_last1),
        .w_ready  (w_ready1),
        .busy     (busy1),
        .done     (done1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: note the handshake seen before the edge, advance, then check the model.
    task automatic cycle();
        bit            acc, stall, last_acc, rst_now, abort_now, start_ok;
        logic [DW-1:0] d0;
        logic [AW-1:0] a0;
        logic          l0;
        acc       = (w_valid === 1'b1) && (w_ready === 1'b1);
        stall     = (w_valid === 1'b1) && (w_ready === 1'b0);
        d0        = w_data;
        a0        = w_addr;
        l0        = w_last;
        rst_now   = rst;
        abort_now = abort;
        start_ok  = start && !run_exp && !abort && !rst;
        last_acc  = 1'b0;
        @(posedge clk);
        #1;
        if (rst_now || abort_now) begin
            run_exp = 1'b0;
            exp_idx = 0;
        end else begin
            if (acc && run_exp) begin
                chk("beat_addr", 32'(a0), 32'(exp_idx));
                chk("beat_data", 32'(d0), 32'(rom_fn(AW'(exp_idx))));
                chk("beat_last", 32'(l0), 32'(exp_idx == D - 1));
                exp_idx++;
                last_acc = (exp_idx == D);
            end
            if (stall && run_exp) begin
                chk("stall_valid", 32'(w_valid), 32'(1));
                chk("stall_data", 32'(w_data), 32'(d0));
                chk("stall_addr", 32'(w_addr), 32'(a0));
                chk("stall_last", 32'(w_last), 32'(l0));
            end
            if (last_acc) begin
                run_exp = 1'b0;
                runs_done++;
            end
            if (start_ok) begin
                run_exp = 1'b1;
                exp_idx = 0;
            end
        end
        chk("done", 32'(done), 32'(last_acc));
        chk("busy", 32'(busy), 32'(run_exp));
        chk("adrs_range", 32'(rom_adrs < AW'(D)), 32'(1));
    endtask

    task automatic wait_for_addr(input int addr, input int max_cycles);
        int n = 0;
        while (!(w_valid === 1'b1 && int'(w_addr) == addr) && n < max_cycles) begin
            cycle();
            n++;
        end
        chk("wait_addr", 32'(w_valid === 1'b1 && int'(w_addr) == addr), 32'(1));
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        cycle();
        while (busy !== 1'b0 && n < max_cycles) begin
            cycle();
            n++;
        end
        chk("wait_idle", 32'(busy), 32'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_adrs"}, 32'(rom_adrs), 32'(0));
        chk({tag, "_data"}, 32'(w_data), 32'(0));
        chk({tag, "_addr"}, 32'(w_addr), 32'(0));
        chk({tag, "_valid"}, 32'(w_valid), 32'(0));
        chk({tag, "_last"}, 32'(w_last), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_done"}, 32'(done), 32'(0));
    endtask

    initial begin
        logic [AW-1:0] hold_adrs;
        int            runs_before;
        int            n;

        rst = 1'b1; start = 1'b0; abort = 1'b0; w_ready = 1'b1;
        start1 = 1'b0; w_ready1 = 1'b1;
        #1;
        cycle();
        cycle();
        rst = 1'b0;
        chk_reset_outputs("reset");
        $display("reset: checked reset values");

        // Full run, ready always high: one beat per cycle, done right after the last accept.
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("lat_not_yet", 32'(w_valid), 32'(0));
        cycle();
        chk("first_data", 32'(w_data), 32'(21'h000160));
        for (int i = 0; i < D; i++) begin
            chk("stream_valid", 32'(w_valid), 32'(1));
            chk("stream_addr", 32'(w_addr), 32'(i));
            if (i == 1) chk("second_data", 32'(w_data), 32'(21'h000271));
            if (i == D - 1) chk("final_data", 32'(w_data), 32'(21'h1FFFC1));
            cycle();
        end
        chk("full_count", 32'(exp_idx), 32'(D));
        cycle();
        $display("full run: %0d beats, runs_done=%0d", exp_idx, runs_done);

        // Five-cycle stall on beat 2, then random backpressure to the end.
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_for_addr(2, 20);
        w_ready   = 1'b0;
        hold_adrs = rom_adrs;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("hold_addr", 32'(w_addr), 32'(2));
            chk("hold_adrs", 32'(rom_adrs), 32'(hold_adrs));
        end
        w_ready = 1'b1;
        cycle();
        chk("resume_valid", 32'(w_valid), 32'(1));
        chk("resume_addr", 32'(w_addr), 32'(3));
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            w_ready = ($urandom_range(0, 99) < 30);
            cycle();
            n++;
        end
        w_ready = 1'b1;
        chk("bp_idle", 32'(busy), 32'(0));
        chk("bp_count", 32'(exp_idx), 32'(D));
        $display("backpressure run: %0d beats in %0d cycles", exp_idx, n);

        // Abort while beat 150 is stalled.
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_for_addr(150, 400);
        w_ready = 1'b0;
        abort   = 1'b1;
        cycle();
        abort = 1'b0;
        w_ready = 1'b1;
        chk("abort_valid", 32'(w_valid), 32'(0));
        chk("abort_last", 32'(w_last), 32'(0));
        chk("abort_adrs", 32'(rom_adrs), 32'(0));
        cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        cycle();
        chk("restart_valid", 32'(w_valid), 32'(1));
        chk("restart_addr", 32'(w_addr), 32'(0));
        wait_idle(400);
        $display("abort/restart: runs_done=%0d", runs_done);

        // start pulses in RUN (addr 40) and in DRAIN are ignored.
        runs_before = runs_done;
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_for_addr(40, 100);
        start = 1'b1;
        cycle();
        start = 1'b0;
        n = 0;
        while (!(w_valid === 1'b1 && w_last === 1'b1) && n < 400) begin
            cycle();
            n++;
        end
        chk("reach_last", 32'(w_valid && w_last), 32'(1));
        w_ready = 1'b0;
        start   = 1'b1;
        cycle();
        start = 1'b0;
        w_ready = 1'b1;
        cycle();
        for (int i = 0; i < 3; i++) cycle();
        chk("ignored_count", 32'(exp_idx), 32'(D));
        chk("single_done", 32'(runs_done - runs_before), 32'(1));
        $display("start-while-busy: runs_done=%0d", runs_done);

        // Reset mid-run at addr 77, then start+abort together in IDLE.
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_for_addr(77, 100);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk_reset_outputs("midrst");
        start = 1'b1;
        abort = 1'b1;
        cycle();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_valid", 32'(w_valid), 32'(0));
        cycle();
        chk("sa_valid2", 32'(w_valid), 32'(0));
        $display("mid-run reset and start+abort: busy=%0b", busy);

        // DEPTH=1 instance: one beat, w_last set, done one cycle after accept.
        start1 = 1'b1;
        cycle();
        start1 = 1'b0;
        chk("d1_lat", 32'(w_valid1), 32'(0));
        chk("d1_busy", 32'(busy1), 32'(1));
        cycle();
        chk("d1_valid", 32'(w_valid1), 32'(1));
        chk("d1_addr", 32'(w_addr1), 32'(0));
        chk("d1_last", 32'(w_last1), 32'(1));
        chk("d1_data", 32'(w_data1), 32'(21'h000160));
        chk("d1_adrs", 32'(rom_adrs1), 32'(0));
        cycle();
        chk("d1_valid_off", 32'(w_valid1), 32'(0));
        chk("d1_done", 32'(done1), 32'(1));
        chk("d1_idle", 32'(busy1), 32'(0));
        cycle();
        chk("d1_done_off", 32'(done1), 32'(0));
        $display("depth-1 instance: single beat checked");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
